// File: rtl/timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timer_ctrl_pkg
// Shared types and constants for the timer controller slice.
//   state_e       : controller FSM state encoding (IDLE, RUN, DONE)
//   MODE_ONESHOT  : stop in DONE after the first compare match
//   MODE_PERIODIC : reload to zero and keep running after each match
// -----------------------------------------------------------------------------
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage : timer_ctrl_pkg

// File: rtl/timer_ctrl_up_cnt_en.sv
// -----------------------------------------------------------------------------
// up_cnt_en
// WIDTH-bit up counter with synchronous clear and enable.
// Clear has priority over enable; arithmetic wraps modulo 2^WIDTH.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear to zero
//   en    : increment by one when clr is low
//   cnt   : registered count value
// -----------------------------------------------------------------------------
module up_cnt_en #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : up_cnt_en

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// Programmable timer controller. Sequences an up counter through start, stop,
// prescale, compare-match and reload, emitting a one-cycle tick on each match.
// Optional build macro: TIMER_CTRL_STICKY_IRQ_EN adds a sticky interrupt.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : strobe; latch config, clear count, begin counting
//   stop    : strobe; abort and return to IDLE (beats start)
//   mode    : 0 one-shot, 1 periodic (sampled with start)
//   cmp_val : terminal count (sampled with start)
//   presc   : prescale divide-minus-one (sampled with start)
//   cnt     : current counter value (registered)
//   tick    : one-cycle pulse on compare match (registered)
//   busy    : high while in RUN
//   done    : high while in DONE (one-shot finished)
//   irq_clr : (macro only) clear the sticky interrupt
//   irq     : (macro only) sticky interrupt, set by tick, set wins over clear
// -----------------------------------------------------------------------------
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [WIDTH-1:0]   cmp_val,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   cnt,
  output logic               tick,
  output logic               busy,
  output logic               done
`ifdef TIMER_CTRL_STICKY_IRQ_EN
  ,
  input  logic               irq_clr,
  output logic               irq
`endif
);

  state_e               state_q,     state_d;
  logic [WIDTH-1:0]     cmp_q,       cmp_d;
  logic [PRESC_W-1:0]   presc_q,     presc_d;
  logic                 mode_q,      mode_d;
  logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
  logic                 tick_q,      tick_d;
  logic                 cnt_clr;
  logic                 cnt_en;

  // NOTE: every always_comb output gets a default first, so no path through
  // the priority chain below can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cmp_d       = cmp_q;
    presc_d     = presc_q;
    mode_d      = mode_q;
    presc_cnt_d = presc_cnt_q;
    tick_d      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    if (stop) begin
      // Abort wins over everything, including a coincident match.
      state_d     = IDLE;
      cnt_clr     = 1'b1;
      presc_cnt_d = '0;
    end else if (start) begin
      // Same action from any state: reload config and restart from zero.
      state_d     = RUN;
      cmp_d       = cmp_val;
      presc_d     = presc;
      mode_d      = mode;
      cnt_clr     = 1'b1;
      presc_cnt_d = '0;
    end else if (state_q == RUN) begin
      if (presc_cnt_q == presc_q) begin
        presc_cnt_d = '0;
        if (cnt == cmp_q) begin
          // Match reloads to zero; no separate wrap path is needed.
          cnt_clr = 1'b1;
          tick_d  = 1'b1;
          if (mode_q == MODE_ONESHOT) begin
            state_d = DONE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end else begin
        presc_cnt_d = presc_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the latched config is reset too (not left as don't-care storage) so
  // the controller powers up in a fully defined state.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmp_q       <= '0;
      presc_q     <= '0;
      mode_q      <= MODE_ONESHOT;
      presc_cnt_q <= '0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmp_q       <= cmp_d;
      presc_q     <= presc_d;
      mode_q      <= mode_d;
      presc_cnt_q <= presc_cnt_d;
      tick_q      <= tick_d;
    end
  end

  up_cnt_en #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt)
  );

  assign tick = tick_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

`ifdef TIMER_CTRL_STICKY_IRQ_EN
  logic irq_q, irq_d;

  // Set from the same-cycle match so irq rises together with tick.
  always_comb begin
    irq_d = tick_d | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule : timer_ctrl
